matmul_seq_ctrl: RTL and testbench

Sequencer for the systolic matrix multiplier. On a start pulse it clears the PE accumulators, then reads matrix A and matrix B out of their two Data_Mem instances into internal operand banks. It then drives the skewed wavefront onto the array's west (A rows) and north (B columns) edges, waits for the array to drain, and signals completion. It sits between the two operand memories and the PE grid, and owns every memory read and every array control strobe.

---
 rtl/matmul_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: systolic array sequencer.
// Loads A/B operand banks, feeds the skewed wavefront, drains, flags done.
module matmul_seq_ctrl #(
  parameter int M          = 3,
  parameter int K          = 3,
  parameter int P          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int A_AW       = $clog2(M*K),
  parameter int B_AW       = $clog2(K*P)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    a_rd_en,
  output logic [A_AW-1:0]         a_addr,
  input  logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    b_rd_en,
  output logic [B_AW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    pe_clear,
  output logic [M*DATA_WIDTH-1:0] a_edge,
  output logic [M-1:0]            a_valid,
  output logic [P*DATA_WIDTH-1:0] b_edge,
  output logic [P-1:0]            b_valid
);

  localparam int DW   = DATA_WIDTH;
  localparam int NA   = M * K;
  localparam int NB   = K * P;
  localparam int L    = (NA > NB) ? NA : NB;
  localparam int F    = K + ((M > P) ? M : P) - 1;
  localparam int D    = M + P - 1;
  localparam int CM1  = (L > F) ? L : F;
  localparam int CMAX = (CM1 > D) ? CM1 : D;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [DW-1:0]   a_bank_q [NA];
  logic [DW-1:0]   a_nx     [NA];
  logic [DW-1:0]   b_bank_q [NB];
  logic [DW-1:0]   b_nx     [NB];

  logic            a_cap_q, b_cap_q;
  logic [A_AW-1:0] a_idx_q;
  logic [B_AW-1:0] b_idx_q;

  logic [M*DW-1:0] a_edge_q, a_edge_d;
  logic [M-1:0]    a_vld_q, a_vld_d;
  logic [P*DW-1:0] b_edge_q, b_edge_d;
  logic [P-1:0]    b_vld_q, b_vld_d;

  // State and phase counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter sequencing through the run phases
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_LOAD;
      S_LOAD:
        if (cnt_q == CW'(L)) state_d = S_FEED;
        else cnt_d = cnt_q + CW'(1);
      S_FEED:
        if (cnt_q == CW'(F - 1)) state_d = S_DRAIN;
        else cnt_d = cnt_q + CW'(1);
      S_DRAIN:
        if (cnt_q == CW'(D - 1)) state_d = S_DONE;
        else cnt_d = cnt_q + CW'(1);
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control strobes and memory read requests decoded from state
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    pe_clear = (state_q == S_CLEAR);
    a_rd_en  = 1'b0;
    a_addr   = '0;
    b_rd_en  = 1'b0;
    b_addr   = '0;
    if (state_q == S_LOAD) begin
      if (int'(cnt_q) < NA) begin
        a_rd_en = 1'b1;
        a_addr  = A_AW'(cnt_q);
      end
      if (int'(cnt_q) < NB) begin
        b_rd_en = 1'b1;
        b_addr  = B_AW'(cnt_q);
      end
    end
  end

  // Remember which slot the in-flight read word belongs to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_cap_q <= 1'b0;
      b_cap_q <= 1'b0;
      a_idx_q <= '0;
      b_idx_q <= '0;
    end else begin
      a_cap_q <= a_rd_en;
      b_cap_q <= b_rd_en;
      a_idx_q <= a_addr;
      b_idx_q <= b_addr;
    end
  end

  // Bank contents including the word arriving this cycle
  always_comb begin
    a_nx = a_bank_q;
    b_nx = b_bank_q;
    if (a_cap_q) a_nx[a_idx_q] = a_rdata;
    if (b_cap_q) b_nx[b_idx_q] = b_rdata;
  end

  // Operand banks keep their contents across reset
  always_ff @(posedge clk) begin
    a_bank_q <= a_nx;
    b_bank_q <= b_nx;
  end

  // Skewed wavefront for the step the next cycle will present
  always_comb begin
    int ka;
    int kb;
    ka       = 0;
    kb       = 0;
    a_edge_d = '0;
    a_vld_d  = '0;
    b_edge_d = '0;
    b_vld_d  = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < M; i++) begin
        ka = int'(cnt_d) - i;
        if (ka >= 0 && ka < K) begin
          a_vld_d[i]          = 1'b1;
          a_edge_d[i*DW +: DW] = a_nx[A_AW'(i*K + ka)];
        end
      end
      for (int j = 0; j < P; j++) begin
        kb = int'(cnt_d) - j;
        if (kb >= 0 && kb < K) begin
          b_vld_d[j]          = 1'b1;
          b_edge_d[j*DW +: DW] = b_nx[B_AW'(kb*P + j)];
        end
      end
    end
  end

  // Registered edge lanes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_edge_q <= '0;
      a_vld_q  <= '0;
      b_edge_q <= '0;
      b_vld_q  <= '0;
    end else begin
      a_edge_q <= a_edge_d;
      a_vld_q  <= a_vld_d;
      b_edge_q <= b_edge_d;
      b_vld_q  <= b_vld_d;
    end
  end

  assign a_edge  = a_edge_q;
  assign a_valid = a_vld_q;
  assign b_edge  = b_edge_q;
  assign b_valid = b_vld_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: bench for the systolic sequencer.
// Two instances (3x3x3 and 2x3x4) against a timeline reference model.
module tb_matmul_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_s, start_n;
  bit   sel;
  int   checks = 0;
  int   errors = 0;
  int   amem [12];
  int   bmem [12];

  logic        busy_s, done_s, pe_clear_s, a_rd_en_s, b_rd_en_s;
  logic [3:0]  a_addr_s, b_addr_s;
  logic [7:0]  a_rdata_s = '0;
  logic [7:0]  b_rdata_s = '0;
  logic [23:0] a_edge_s, b_edge_s;
  logic [2:0]  a_valid_s, b_valid_s;

  logic        busy_n, done_n, pe_clear_n, a_rd_en_n, b_rd_en_n;
  logic [2:0]  a_addr_n;
  logic [3:0]  b_addr_n;
  logic [7:0]  a_rdata_n = '0;
  logic [7:0]  b_rdata_n = '0;
  logic [15:0] a_edge_n;
  logic [31:0] b_edge_n;
  logic [1:0]  a_valid_n;
  logic [3:0]  b_valid_n;

  matmul_seq_ctrl #(.M(3), .K(3), .P(3), .DATA_WIDTH(8)) u_sq (
    .clk(clk), .reset(reset), .start(start_s),
    .busy(busy_s), .done(done_s),
    .a_rd_en(a_rd_en_s), .a_addr(a_addr_s), .a_rdata(a_rdata_s),
    .b_rd_en(b_rd_en_s), .b_addr(b_addr_s), .b_rdata(b_rdata_s),
    .pe_clear(pe_clear_s),
    .a_edge(a_edge_s), .a_valid(a_valid_s),
    .b_edge(b_edge_s), .b_valid(b_valid_s)
  );

  matmul_seq_ctrl #(.M(2), .K(3), .P(4), .DATA_WIDTH(8)) u_ns (
    .clk(clk), .reset(reset), .start(start_n),
    .busy(busy_n), .done(done_n),
    .a_rd_en(a_rd_en_n), .a_addr(a_addr_n), .a_rdata(a_rdata_n),
    .b_rd_en(b_rd_en_n), .b_addr(b_addr_n), .b_rdata(b_rdata_n),
    .pe_clear(pe_clear_n),
    .a_edge(a_edge_n), .a_valid(a_valid_n),
    .b_edge(b_edge_n), .b_valid(b_valid_n)
  );

  // Operand memories: one-cycle read latency
  always @(posedge clk) begin
    if (a_rd_en_s) a_rdata_s <= 8'(amem[a_addr_s]);
    if (b_rd_en_s) b_rdata_s <= 8'(bmem[b_addr_s]);
    if (a_rd_en_n) a_rdata_n <= 8'(amem[a_addr_n]);
    if (b_rd_en_n) b_rdata_n <= 8'(bmem[b_addr_n]);
  end

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pe_clear;
    logic        a_rd_en;
    logic [7:0]  a_addr;
    logic        b_rd_en;
    logic [7:0]  b_addr;
    logic [7:0]  a_valid;
    logic [31:0] a_edge;
    logic [7:0]  b_valid;
    logic [31:0] b_edge;
  } obs_t;

  obs_t o, e;

  function automatic obs_t observe();
    obs_t r;
    r = '0;
    if (!sel) begin
      r.busy = busy_s; r.done = done_s; r.pe_clear = pe_clear_s;
      r.a_rd_en = a_rd_en_s; r.a_addr = 8'(a_addr_s);
      r.b_rd_en = b_rd_en_s; r.b_addr = 8'(b_addr_s);
      r.a_valid = 8'(a_valid_s); r.a_edge = 32'(a_edge_s);
      r.b_valid = 8'(b_valid_s); r.b_edge = 32'(b_edge_s);
    end else begin
      r.busy = busy_n; r.done = done_n; r.pe_clear = pe_clear_n;
      r.a_rd_en = a_rd_en_n; r.a_addr = 8'(a_addr_n);
      r.b_rd_en = b_rd_en_n; r.b_addr = 8'(b_addr_n);
      r.a_valid = 8'(a_valid_n); r.a_edge = 32'(a_edge_n);
      r.b_valid = 8'(b_valid_n); r.b_edge = 32'(b_edge_n);
    end
    return r;
  endfunction

  // Expected outputs n cycles after the start-sampling edge
  function automatic obs_t model(int n, int m, int k, int p);
    obs_t r;
    int l, f, d, c, t, w;
    r = '0;
    l = (m*k > k*p) ? m*k : k*p;
    f = k + ((m > p) ? m : p) - 1;
    d = m + p - 1;
    if (n < 1 || n > l + f + d + 3) return r;
    r.busy = 1'b1;
    if (n == 1) begin
      r.pe_clear = 1'b1;
    end else if (n <= l + 2) begin
      c = n - 2;
      if (c < m*k) begin r.a_rd_en = 1'b1; r.a_addr = 8'(c); end
      if (c < k*p) begin r.b_rd_en = 1'b1; r.b_addr = 8'(c); end
    end else if (n <= l + 2 + f) begin
      t = n - l - 3;
      for (int i = 0; i < m; i++) begin
        w = t - i;
        if (w >= 0 && w < k) begin
          r.a_valid[i] = 1'b1;
          r.a_edge[i*8 +: 8] = 8'(amem[i*k + w]);
        end
      end
      for (int j = 0; j < p; j++) begin
        w = t - j;
        if (w >= 0 && w < k) begin
          r.b_valid[j] = 1'b1;
          r.b_edge[j*8 +: 8] = 8'(bmem[w*p + j]);
        end
      end
    end else if (n == l + f + d + 3) begin
      r.done = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 12; i++) begin
      amem[i] = int'($urandom_range(0, 255));
      bmem[i] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic test_reset();
    sel = 0;
    fill_random();
    reset = 1'b0;
    start_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      o = observe();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got %h exp 0", i, o);
      end
    end
    reset = 1'b1;
    tick();
    start_s = 1'b0;
    checks++;
    if (busy_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_busy got %b exp 1", busy_s);
    end
    for (int n = 1; n <= 23; n++) begin
      o = observe();
      e = model(n, 3, 3, 3);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_run n=%0d got %h exp %h", n, o, e);
      end
      tick();
    end
  endtask

  task automatic test_walk();
    int done_at;
    sel = 0;
    done_at = -1;
    for (int i = 0; i < 9; i++) begin
      amem[i] = i + 1;
      bmem[i] = 9 - i;
    end
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int n = 1; n <= 23; n++) begin
      o = observe();
      e = model(n, 3, 3, 3);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL walk n=%0d got %h exp %h", n, o, e);
      end
      if (done_s === 1'b1) done_at = n;
      if (n == 12) begin
        checks++;
        if ({a_valid_s, b_valid_s, a_edge_s[7:0], b_edge_s[7:0]}
            !== {3'b001, 3'b001, 8'd1, 8'd9}) begin
          errors++;
          $display("FAIL walk_feed0 got %b %b %0d %0d exp 001 001 1 9",
                   a_valid_s, b_valid_s, a_edge_s[7:0], b_edge_s[7:0]);
        end
      end
      if (n == 14) begin
        checks++;
        if ({a_edge_s[23:16], b_edge_s[23:16]} !== {8'd7, 8'd7}) begin
          errors++;
          $display("FAIL walk_feed2 got %0d %0d exp 7 7",
                   a_edge_s[23:16], b_edge_s[23:16]);
        end
      end
      if (n == 16) begin
        checks++;
        if ({a_valid_s, b_valid_s, a_edge_s[23:16], b_edge_s[23:16]}
            !== {3'b100, 3'b100, 8'd9, 8'd1}) begin
          errors++;
          $display("FAIL walk_feed4 got %b %b %0d %0d exp 100 100 9 1",
                   a_valid_s, b_valid_s, a_edge_s[23:16], b_edge_s[23:16]);
        end
      end
      tick();
    end
    checks++;
    if (done_at != 22) begin
      errors++;
      $display("FAIL walk_done_cycle got %0d exp 22", done_at);
    end
  endtask

  task automatic test_nonsquare();
    int acnt, bcnt, v3cnt, done_at;
    sel = 1;
    acnt = 0; bcnt = 0; v3cnt = 0; done_at = -1;
    fill_random();
    start_n = 1'b1;
    tick();
    start_n = 1'b0;
    for (int n = 1; n <= 27; n++) begin
      o = observe();
      e = model(n, 2, 3, 4);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL nonsq n=%0d got %h exp %h", n, o, e);
      end
      if (a_rd_en_n === 1'b1) acnt++;
      if (b_rd_en_n === 1'b1) bcnt++;
      if (b_valid_n[3] === 1'b1 && n >= 18 && n <= 20) v3cnt++;
      if (done_n === 1'b1) done_at = n;
      tick();
    end
    checks++;
    if (acnt != 6 || bcnt != 12) begin
      errors++;
      $display("FAIL nonsq_rd_counts got %0d %0d exp 6 12", acnt, bcnt);
    end
    checks++;
    if (v3cnt != 3) begin
      errors++;
      $display("FAIL nonsq_bvalid3 got %0d exp 3", v3cnt);
    end
    checks++;
    if (done_at != 26) begin
      errors++;
      $display("FAIL nonsq_done_cycle got %0d exp 26", done_at);
    end
    sel = 0;
  endtask

  task automatic test_repulse();
    int dcnt, ccnt;
    sel = 0;
    dcnt = 0; ccnt = 0;
    fill_random();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int n = 1; n <= 27; n++) begin
      o = observe();
      e = model(n, 3, 3, 3);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL repulse n=%0d got %h exp %h", n, o, e);
      end
      if (done_s === 1'b1) dcnt++;
      if (pe_clear_s === 1'b1) ccnt++;
      if (n == 13) start_s = 1'b1;
      if (n == 15) start_s = 1'b0;
      tick();
    end
    checks++;
    if (dcnt != 1 || ccnt != 1) begin
      errors++;
      $display("FAIL repulse_counts got done=%0d clr=%0d exp 1 1", dcnt, ccnt);
    end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    sel = 0;
    dcnt = 0;
    fill_random();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      o = observe();
      e = model(n, 3, 3, 3);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL resetmid_pre n=%0d got %h exp %h", n, o, e);
      end
      if (n < 14) tick();
    end
    #2;
    reset = 1'b0;
    #1;
    o = observe();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL resetmid_async got %h exp 0", o);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      o = observe();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL resetmid_low cyc=%0d got %h exp 0", i, o);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      o = observe();
      if (done_s === 1'b1) dcnt++;
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL resetmid_idle cyc=%0d got %h exp 0", i, o);
      end
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL resetmid_no_done got %0d exp 0", dcnt);
    end
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int n = 1; n <= 23; n++) begin
      o = observe();
      e = model(n, 3, 3, 3);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL resetmid_rerun n=%0d got %h exp %h", n, o, e);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int dcnt, ccnt;
    sel = 0;
    dcnt = 0; ccnt = 0;
    fill_random();
    start_s = 1'b1;
    tick();
    for (int n = 1; n <= 69; n++) begin
      if (n == 60) start_s = 1'b0;
      o = observe();
      e = model(((n - 1) % 23) + 1, 3, 3, 3);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b n=%0d got %h exp %h", n, o, e);
      end
      if (done_s === 1'b1) dcnt++;
      if (pe_clear_s === 1'b1) ccnt++;
      tick();
    end
    checks++;
    if (dcnt != 3 || ccnt != 3) begin
      errors++;
      $display("FAIL b2b_counts got done=%0d clr=%0d exp 3 3", dcnt, ccnt);
    end
  endtask

  initial begin
    reset = 1'b0;
    start_s = 1'b0;
    start_n = 1'b0;
    sel = 0;
    test_reset();
    test_walk();
    test_nonsquare();
    test_repulse();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
